// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader_pkg
// Purpose  : Shared types and constants for the configuration-chain loader.
// Revision : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    // Width of one bitstream word accepted over the handshake
    localparam int CCFF_BYTE_W = 8;
    // Width of the shift-register fill count (holds 0..CCFF_BYTE_W)
    localparam int CCFF_FILL_W = $clog2(CCFF_BYTE_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ccff_state_e;

endpackage
`default_nettype wire

// File: rtl/ccff_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ccff_serializer
// Purpose  : Byte shift register feeding the configuration chain MSB-first.
//            Head bit and clock-gate enable are registered and describe the
//            shift that will happen in the following cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_serializer
    import ccff_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,        // drop any buffered bits
    input  logic                   i_load,         // accept a new byte
    input  logic                   i_shift,        // a bit leaves the register this cycle
    input  logic                   i_active_next,  // loader will be in LOAD next cycle
    input  logic [CCFF_BYTE_W-1:0] i_data,
    output logic [CCFF_FILL_W-1:0] o_fill,
    output logic                   o_head,
    output logic                   o_clk_en
);

    logic [CCFF_BYTE_W-1:0] r_sr;
    logic [CCFF_BYTE_W-1:0] w_sr_next;
    logic [CCFF_FILL_W-1:0] r_fill;
    logic [CCFF_FILL_W-1:0] w_fill_next;
    logic                   w_shift_next;
    logic                   r_head;
    logic                   r_clk_en;

    // Next shift-register contents: a load overrides the shift of the last bit
    always_comb begin
        w_sr_next   = r_sr;
        w_fill_next = r_fill;
        if (i_clear) begin
            w_sr_next   = '0;
            w_fill_next = '0;
        end else if (i_load) begin
            w_sr_next   = i_data;
            w_fill_next = CCFF_FILL_W'(CCFF_BYTE_W);
        end else if (i_shift) begin
            w_sr_next   = {r_sr[CCFF_BYTE_W-2:0], 1'b0};
            w_fill_next = r_fill - 1'b1;
        end
    end

    // Next cycle is a shift cycle when still loading and bits remain buffered
    assign w_shift_next = i_active_next && (w_fill_next != '0);

    // Register the buffer and the glitch-free head/enable pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr     <= '0;
            r_fill   <= '0;
            r_head   <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            r_sr     <= w_sr_next;
            r_fill   <= w_fill_next;
            r_head   <= w_shift_next ? w_sr_next[CCFF_BYTE_W-1] : 1'b0;
            r_clk_en <= w_shift_next;
        end
    end

    assign o_fill   = r_fill;
    assign o_head   = r_head;
    assign o_clk_en = r_clk_en;

endmodule
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Purpose  : Byte-wide loader for the fabric configuration chain. Owns the
//            load FSM, shifted-bit counter, readback parity and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter  int CHAIN_LEN = 64,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                   prog_clk,
    input  logic                   prog_reset,
    input  logic                   cfg_start,
    input  logic [CCFF_BYTE_W-1:0] cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   ccff_head,
    input  logic                   ccff_tail,
    output logic                   prog_clk_en,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic [CNT_W-1:0]       bits_shifted,
    output logic                   tail_parity
);

    // Wide enough for bits_shifted + fill without overflow
    localparam int               c_sum_w     = ((CNT_W > CCFF_FILL_W) ? CNT_W : CCFF_FILL_W) + 1;
    localparam logic [c_sum_w-1:0] c_len_ext = c_sum_w'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_len       = CNT_W'(CHAIN_LEN);

    ccff_state_e            r_state;
    ccff_state_e            w_state_next;
    logic [CNT_W-1:0]       r_bits;
    logic [CNT_W-1:0]       w_bits_next;
    logic                   r_parity;
    logic                   r_error;
    logic                   r_busy;
    logic                   r_done;
    logic [CCFF_FILL_W-1:0] w_fill;
    logic [c_sum_w-1:0]     w_sum;
    logic                   w_in_load;
    logic                   w_shift;
    logic                   w_accept;
    logic                   w_start_ok;
    logic                   w_finish;
    logic                   w_err_set;

    assign w_in_load  = (r_state == LOAD);
    assign w_shift    = w_in_load && (w_fill != '0) && (c_sum_w'(r_bits) < c_len_ext);
    assign w_sum      = c_sum_w'(r_bits) + c_sum_w'(w_fill);
    // Ready when empty, or when the last buffered bit leaves this cycle,
    // and only while the chain still has room for more bits
    assign cfg_ready  = w_in_load
                        && ((w_fill == '0) || ((w_fill == CCFF_FILL_W'(1)) && w_shift))
                        && (w_sum < c_len_ext);
    assign w_accept   = cfg_valid && cfg_ready;
    assign w_start_ok = cfg_start && !w_in_load;
    assign w_bits_next = r_bits + CNT_W'(w_shift);
    assign w_finish   = w_shift && (w_bits_next == c_len);
    assign w_err_set  = (cfg_start && w_in_load) || (cfg_valid && !w_in_load);

    // Next-state selection: a start outside LOAD always (re)starts a load
    always_comb begin
        w_state_next = r_state;
        if (w_start_ok) begin
            w_state_next = LOAD;
        end else if (w_finish) begin
            w_state_next = DONE;
        end
    end

    // FSM, counters, readback parity and sticky error
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            r_state  <= IDLE;
            r_bits   <= '0;
            r_parity <= 1'b0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == LOAD);
            r_done  <= (w_state_next == DONE);
            if (w_start_ok) begin
                r_bits   <= '0;
                r_parity <= 1'b0;
                r_error  <= w_err_set;
            end else begin
                if (w_shift) begin
                    r_bits   <= w_bits_next;
                    r_parity <= r_parity ^ ccff_tail;
                end
                if (w_err_set) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    ccff_serializer u_serializer (
        .clk           (prog_clk),
        .rst           (prog_reset),
        .i_clear       (w_start_ok || w_finish),
        .i_load        (w_accept),
        .i_shift       (w_shift),
        .i_active_next (w_state_next == LOAD),
        .i_data        (cfg_data),
        .o_fill        (w_fill),
        .o_head        (ccff_head),
        .o_clk_en      (prog_clk_en)
    );

    assign cfg_busy     = r_busy;
    assign cfg_done     = r_done;
    assign cfg_error    = r_error;
    assign bits_shifted = r_bits;
    assign tail_parity  = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ccff_bitstream_loader
// Purpose  : Self-checking bench for the configuration-chain loader with a
//            16-bit chain model (scoreboarded) and a 12-bit partial-byte case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic prog_reset;

    // 16-bit chain instance
    logic       cfg_start, cfg_valid, cfg_ready, ccff_head, ccff_tail, prog_clk_en;
    logic       cfg_busy, cfg_done, cfg_error, tail_parity;
    logic [7:0] cfg_data;
    logic [4:0] bits_shifted;

    // 12-bit chain instance
    logic       start12, valid12, ready12, head12, en12, busy12, done12, err12, par12;
    logic       tail12;
    logic [7:0] data12;
    logic [3:0] bits12;

    ccff_bitstream_loader #(.CHAIN_LEN(16)) dut (
        .prog_clk(clk), .prog_reset(prog_reset), .cfg_start(cfg_start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .bits_shifted(bits_shifted), .tail_parity(tail_parity)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(12)) dut12 (
        .prog_clk(clk), .prog_reset(prog_reset), .cfg_start(start12),
        .cfg_data(data12), .cfg_valid(valid12), .cfg_ready(ready12),
        .ccff_head(head12), .ccff_tail(tail12), .prog_clk_en(en12),
        .cfg_busy(busy12), .cfg_done(done12), .cfg_error(err12),
        .bits_shifted(bits12), .tail_parity(par12)
    );

    // External chain model clocked by the gated prog_clk
    logic [15:0] chain = 16'h0000;
    logic [15:0] preload_val = 16'h0000;
    logic        preload_req = 1'b0;
    assign ccff_tail = chain[15];
    assign tail12    = 1'b0;

    always @(posedge clk) begin
        if (preload_req)      chain <= preload_val;
        else if (prog_clk_en) chain <= {chain[14:0], ccff_head};
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the 16-bit instance
    logic  sb[$];
    int    pushed = 0;
    int    cyc = 0;
    int    en_cnt = 0;
    int    first_en = -1;
    int    last_en = -1;
    logic [15:0] stream = 16'h0;
    int    en12_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (!prog_reset) begin
            if (cfg_valid && cfg_ready) begin
                for (int i = 7; i >= 0; i--) begin
                    if (pushed < 16) begin
                        sb.push_back(cfg_data[i]);
                        pushed++;
                    end
                end
            end
            if (prog_clk_en) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                stream = {stream[14:0], ccff_head};
                if (sb.size() == 0) begin
                    check("head_unexpected", 32'(ccff_head), 32'h2);
                end else begin
                    check("head", 32'(ccff_head), 32'(sb.pop_front()));
                end
            end
            if (en12) begin
                en12_cnt++;
                check("head12_ones", 32'(head12), 32'h1);
            end
        end
    end

    task automatic do_preload(input logic [15:0] v);
        @(posedge clk); #1;
        preload_val = v;
        preload_req = 1'b1;
        @(posedge clk); #1;
        preload_req = 1'b0;
    endtask

    task automatic do_start16();
        @(posedge clk); #1;
        cfg_start = 1'b1;
        pushed = 0;
        sb.delete();
        en_cnt = 0;
        first_en = -1;
        last_en = -1;
        stream = 16'h0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_ready16();
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) check("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic send16(input logic [7:0] b);
        cfg_data  = b;
        cfg_valid = 1'b1;
        wait_ready16();
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done16();
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done16", 32'(cfg_done), 32'h1);
    endtask

    task automatic wait_sig12(input int which);
        int n;
        n = 0;
        @(negedge clk);
        while (!((which == 0) ? ready12 : done12) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check((which == 0) ? "ready12_wait" : "done12", 32'((which == 0) ? ready12 : done12), 32'h1);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          gap;
        logic [15:0] pre;
        logic [15:0] exp_stream;
        logic        exp_par;
        int          exp_span;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 0, 16'h8001, 16'hA53C, 1'b0, 16};
        vecs[1] = '{8'hA5, 8'h3C, 3, 16'h0001, 16'hA53C, 1'b1, 19};
        vecs[2] = '{8'h00, 8'hFF, 0, 16'hFFFF, 16'h00FF, 1'b0, 16};
        vecs[3] = '{8'hC3, 8'h81, 3, 16'h1234, 16'hC381, 1'b1, 19};

        prog_reset = 1'b1;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        start12 = 1'b0; valid12 = 1'b0; data12 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset16", {20'h0, cfg_ready, ccff_head, prog_clk_en, cfg_busy, cfg_done,
                          cfg_error, tail_parity, bits_shifted}, 32'h0);
        check("reset12", {21'h0, ready12, head12, en12, busy12, done12, err12, par12, bits12}, 32'h0);
        @(posedge clk); #1;
        prog_reset = 1'b0;

        // Table-driven full loads
        for (int i = 0; i < 4; i++) begin
            do_preload(vecs[i].pre);
            do_start16();
            send16(vecs[i].b0);
            if (vecs[i].gap > 0) begin
                wait_ready16();
                repeat (vecs[i].gap) @(posedge clk);
                #1;
            end
            send16(vecs[i].b1);
            wait_done16();
            check($sformatf("stream[%0d]", i), 32'(stream), 32'(vecs[i].exp_stream));
            check($sformatf("en_cnt[%0d]", i), 32'(en_cnt), 32'd16);
            check($sformatf("span[%0d]", i), 32'(last_en - first_en + 1), 32'(vecs[i].exp_span));
            check($sformatf("bits[%0d]", i), 32'(bits_shifted), 32'd16);
            check($sformatf("parity[%0d]", i), 32'(tail_parity), 32'(vecs[i].exp_par));
            check($sformatf("err_busy[%0d]", i), {30'h0, cfg_error, cfg_busy}, 32'h0);
            check($sformatf("sb_empty[%0d]", i), 32'(sb.size()), 32'h0);
        end

        // Partial final byte on the 12-bit chain
        @(posedge clk); #1;
        start12 = 1'b1;
        en12_cnt = 0;
        @(posedge clk); #1;
        start12 = 1'b0;
        data12 = 8'hFF; valid12 = 1'b1;
        wait_sig12(0);
        @(posedge clk); #1;
        data12 = 8'hF0;
        wait_sig12(0);
        @(posedge clk); #1;
        valid12 = 1'b0;
        wait_sig12(1);
        repeat (3) @(negedge clk);
        check("en12_cnt", 32'(en12_cnt), 32'd12);
        check("bits12", 32'(bits12), 32'd12);
        check("done12_err", {30'h0, done12, err12}, 32'h2);

        // Valid presented in DONE: not accepted, flags an error
        @(posedge clk); #1;
        cfg_data = 8'h55; cfg_valid = 1'b1;
        @(negedge clk);
        check("ready_in_done", 32'(cfg_ready), 32'h0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("err_valid_done", {30'h0, cfg_error, cfg_done}, 32'h3);

        // Start clears the error; a start mid-load sets it and is ignored
        do_preload(16'h8001);
        do_start16();
        @(negedge clk);
        check("err_cleared", 32'(cfg_error), 32'h0);
        @(posedge clk); #1;
        send16(8'hA5);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("err_start_in_load", {30'h0, cfg_error, cfg_busy}, 32'h3);
        @(posedge clk); #1;
        send16(8'h3C);
        wait_done16();
        check("stream_restart", 32'(stream), 32'hA53C);
        check("bits_restart", 32'(bits_shifted), 32'd16);
        check("err_sticky", 32'(cfg_error), 32'h1);

        // Asynchronous reset after five bits, then a clean full reload
        do_preload(16'h0000);
        do_start16();
        send16(8'hA5);
        begin
            int n;
            n = 0;
            while (en_cnt < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("five_bits", 32'(en_cnt), 32'd5);
        end
        #1;
        prog_reset = 1'b1;
        #1;
        check("async_reset", {20'h0, cfg_ready, ccff_head, prog_clk_en, cfg_busy, cfg_done,
                              cfg_error, tail_parity, bits_shifted}, 32'h0);
        @(posedge clk); #1;
        prog_reset = 1'b0;
        do_preload(16'h8001);
        do_start16();
        send16(8'h5A);
        send16(8'hC3);
        wait_done16();
        check("stream_after_reset", 32'(stream), 32'h5AC3);
        check("parity_after_reset", {27'h0, tail_parity, bits_shifted}, 32'h10);
        check("chain_contents", 32'(chain), 32'h5AC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Byte-wide configuration loader that sits directly upstream of the fabric configuration chain.
- Accepts bitstream bytes over a valid/ready handshake and serializes them MSB-first onto ccff_head of the first tile (e.g. the left IO column).
- Drives the enable of an external clock gate on prog_clk, so the chain only shifts when a valid bit is presented.
- Monitors ccff_tail of the last tile to report readback parity and load completion.

Parameters:
- CHAIN_LEN, 64, total configuration flops in the chain; range 1..65535.
- CNT_W, $clog2(CHAIN_LEN+1), width of the shifted-bit counter (derived, not overridden).

Ports:
- prog_clk  input  1  configuration clock, rising edge; free-running into the loader.
- prog_reset  input  1  asynchronous, active-high reset.
- cfg_start  input  1  single-cycle pulse; begins a load.
- cfg_data  input  8  bitstream byte, MSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit into the chain head (registered).
- ccff_tail  input  1  serial bit out of the chain tail.
- prog_clk_en  output  1  enable for the external latch-based ICG producing the chain's gated prog_clk (registered).
- cfg_busy  output  1  high in LOAD.
- cfg_done  output  1  high in DONE.
- cfg_error  output  1  sticky protocol error.
- bits_shifted  output  CNT_W  count of bits shifted in the current or last load.
- tail_parity  output  1  XOR of ccff_tail sampled on every shift cycle of the current or last load.

Behaviour:
- Reset values (asynchronous, active-high): state IDLE; all outputs 0; shift register, bit count and bits_in_sr all 0.
- States: IDLE, LOAD, DONE.
  - IDLE -> LOAD on cfg_start. At the same time clear bits_shifted, tail_parity, cfg_error and the shift register.
  - LOAD -> DONE on the edge where bits_shifted reaches CHAIN_LEN.
  - DONE -> LOAD on cfg_start, which starts a reload and clears the same state.
- Shift register: 8 bits with a fill count bits_in_sr (0..8).
- Shift cycle: in LOAD, bits_in_sr>0 and bits_shifted<CHAIN_LEN.
  - ccff_head = sr[7] and prog_clk_en = 1 in that cycle.
  - At the edge: sr shifts left, bits_in_sr decrements, bits_shifted increments, tail_parity ^= ccff_tail.
- Outside shift cycles prog_clk_en = 0 and ccff_head holds 0.
- Handshake:
  - cfg_ready = LOAD && (bits_in_sr==0 || (bits_in_sr==1 && shift cycle)) && bits_shifted + bits_in_sr < CHAIN_LEN.
  - Transfer occurs on cfg_valid && cfg_ready: load sr = cfg_data and bits_in_sr = 8.
  - A refill in the cycle the last bit shifts is allowed, giving a sustained 1 bit/cycle with no bubble.
- Final partial byte: when CHAIN_LEN mod 8 = r != 0, only the r MSBs of the last byte are shifted. The remaining bits are discarded and bits_in_sr is cleared on entering DONE.
- Latency: first ccff_head bit/prog_clk_en appears the cycle after the accepting edge.
- Readback: tail_parity covers exactly the CHAIN_LEN bits pushed out, i.e. the previous configuration. Chain reset to 0 gives parity 0.
- cfg_error is set (sticky until next accepted start) on:
  - cfg_start while in LOAD; the start is otherwise ignored and the load continues;
  - cfg_valid while in IDLE or DONE (cfg_ready=0, byte not consumed).
- cfg_valid with cfg_ready=0 in LOAD is normal backpressure; no shift occurs while starved (prog_clk_en=0).
- Reset mid-load: immediate return to IDLE with outputs 0. The chain is left partially loaded, and the next load fully overwrites it.

Decomposition:
- Shared package ccff_loader_pkg:
  - state enum {IDLE, LOAD, DONE};
  - CCFF_BYTE_W = 8.
- One sub-module, ccff_serializer: 8-bit shift register, fill count, head/enable registers, refill logic.
- Top level owns the FSM, counters, parity and error logic.

Test Plan:
- CHAIN_LEN=16, start, bytes 0xA5,0x3C with valid held -> ccff_head sequence 1010010100111100 on 16 consecutive prog_clk_en cycles, no bubble; cfg_done=1, bits_shifted=16.
- CHAIN_LEN=12, bytes 0xFF,0xF0 -> exactly 12 enable cycles, all ones; low nibble of 0xF0 never appears; DONE.
- Valid toggled every other byte with 3-cycle gaps -> prog_clk_en low during gaps; shifted stream identical to the gap-free case.
- Model chain = 16-bit shift register preloaded 0x8001; load completes -> tail_parity=0. Preload 0x0001 -> tail_parity=1.
- cfg_start mid-load -> cfg_error=1, load completes normally. cfg_valid in DONE -> cfg_ready=0, cfg_error=1.
- prog_reset asserted after 5 bits -> all outputs 0 asynchronously. New start then reloads the full 16 bits correctly.
